// File: rtl/alu_pkg.sv
// Shared opcode encoding and latency constant for the ALU request scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,  // a + b
    OP_SUB_AB = 2'd1,  // a - b
    OP_SUB_BA = 2'd2,  // b - a
    OP_MUL    = 2'd3   // low DATAW bits of a * b
  } alu_op_e;

  // Input-to-result latency of the shared pipelined ALU.
  localparam int ALU_LAT_C = 2;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response FIFO: holds {id, result} words until the consumer takes them.
// Latency: a push is visible at head_vld/head_dat the cycle after the push.
// Backpressure: pop only when head_vld; push when full must never happen (upstream credit).
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   push, push_dat     write strobe and data
//   pop                read strobe, ignored while empty
//   head_vld, head_dat oldest entry, valid while count != 0
//   count              registered occupancy
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic                         head_vld,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign do_pop   = pop & head_vld;

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin sharing of one pipelined ALU among NREQ requesters, results returned with requester id.
// Latency: grant is combinational; response valid ALU_LAT+1 cycles after the grant cycle.
// Backpressure: issue is credit-gated on FIFO + in-flight occupancy, so rsp_ready low never drops a result.
//
// Ports:
//   clk, rst_n                           clock, async active-low reset
//   req_valid/req_ready                  per-requester handshake (req_ready one-hot or zero)
//   req_opcode/req_dataa/req_datab       packed per-requester payload, requester i at slice i
//   alu_opcode/alu_dataa/alu_datab       ALU inputs (zero when nothing is granted)
//   alu_result                           ALU output, ALU_LAT cycles after its inputs
//   rsp_valid/rsp_ready/rsp_id/rsp_result response channel
//   busy                                 any op in flight or buffered
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATAW     = 16,
  parameter int OPCODEW   = 2,
  parameter int ALU_LAT   = ALU_LAT_C,
  parameter int RSP_DEPTH = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*OPCODEW-1:0]   req_opcode,
  input  logic [NREQ*DATAW-1:0]     req_dataa,
  input  logic [NREQ*DATAW-1:0]     req_datab,
  output logic [OPCODEW-1:0]        alu_opcode,
  output logic [DATAW-1:0]          alu_dataa,
  output logic [DATAW-1:0]          alu_datab,
  input  logic [DATAW-1:0]          alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [DATAW-1:0]          rsp_result,
  output logic                      busy
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int SW = $clog2(RSP_DEPTH + ALU_LAT + 1);

  // run holds grants off while in reset and until the first edge after release.
  logic               run;
  logic [IDW-1:0]     ptr;
  logic [ALU_LAT-1:0] pipe_vld;
  logic [IDW-1:0]     pipe_id [ALU_LAT];
  logic [CW-1:0]      fifo_count;
  logic [SW-1:0]      inflight;
  logic [SW-1:0]      used;
  logic               can_issue;
  logic               grant_any;
  logic [IDW-1:0]     gid;
  logic [IDW:0]       idx;

  // Credit uses registered occupancy only; a pop this cycle frees credit next cycle.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < ALU_LAT; k++) inflight = inflight + SW'(pipe_vld[k]);
    used = SW'(fifo_count) + inflight;
  end
  assign can_issue = used < SW'(RSP_DEPTH);

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    gid       = '0;
    idx       = '0;
    if (run && can_issue) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = {1'b0, ptr} + (IDW+1)'(k);
        if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
        if (!grant_any && req_valid[idx[IDW-1:0]]) begin
          grant_any = 1'b1;
          gid       = idx[IDW-1:0];
        end
      end
    end
  end

  assign req_ready = grant_any ? (NREQ'(1) << gid) : '0;

  always_comb begin
    alu_opcode = '0;
    alu_dataa  = '0;
    alu_datab  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && (gid == IDW'(i))) begin
        alu_opcode = req_opcode[i*OPCODEW +: OPCODEW];
        alu_dataa  = req_dataa[i*DATAW +: DATAW];
        alu_datab  = req_datab[i*DATAW +: DATAW];
      end
    end
  end

  // ptr and the in-flight shift register mirror the ALU pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      ptr      <= '0;
      pipe_vld <= '0;
      for (int k = 0; k < ALU_LAT; k++) pipe_id[k] <= '0;
    end else begin
      run <= 1'b1;
      if (grant_any) ptr <= (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);
      pipe_vld[0] <= grant_any;
      pipe_id[0]  <= gid;
      for (int k = 1; k < ALU_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_id[k]  <= pipe_id[k-1];
      end
    end
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (IDW + DATAW)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pipe_vld[ALU_LAT-1]),
    .push_dat ({pipe_id[ALU_LAT-1], alu_result}),
    .pop      (rsp_ready),
    .head_vld (rsp_valid),
    .head_dat ({rsp_id, rsp_result}),
    .count    (fifo_count)
  );

  assign busy = (|pipe_vld) | (fifo_count != '0);

endmodule

// File: tb/tb_alu_req_scheduler.sv
module tb_alu_req_scheduler;
  import alu_pkg::*;

  localparam int NREQ = 4, DATAW = 16, OPCODEW = 2, IDW = 2, RSP_DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*OPCODEW-1:0] req_opcode;
  logic [NREQ*DATAW-1:0]   req_dataa;
  logic [NREQ*DATAW-1:0]   req_datab;
  logic [OPCODEW-1:0]      alu_opcode;
  logic [DATAW-1:0]        alu_dataa;
  logic [DATAW-1:0]        alu_datab;
  logic [DATAW-1:0]        alu_result;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [DATAW-1:0]        rsp_result;
  logic                    busy;

  always #5 clk = ~clk;

  alu_req_scheduler #(
    .NREQ(NREQ), .DATAW(DATAW), .OPCODEW(OPCODEW), .ALU_LAT(2), .RSP_DEPTH(RSP_DEPTH), .IDW(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_dataa(req_dataa), .req_datab(req_datab),
    .alu_opcode(alu_opcode), .alu_dataa(alu_dataa), .alu_datab(alu_datab),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy)
  );

  function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return b - a;
      default: begin p = {16'b0, a} * {16'b0, b}; return p[15:0]; end
    endcase
  endfunction

  // Two-stage ALU model
  logic [DATAW-1:0] alu_s1;
  always @(posedge clk) begin
    alu_s1     <= alu_ref(alu_opcode, alu_dataa, alu_datab);
    alu_result <= alu_s1;
  end

  int total = 0;
  int bad   = 0;
  logic [IDW+DATAW-1:0] expq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req_opcode[i*OPCODEW +: OPCODEW] = op;
    req_dataa[i*DATAW +: DATAW]      = a;
    req_datab[i*DATAW +: DATAW]      = b;
  endtask

  // Compare an accepted response against the scoreboard head.
  task automatic watch_rsp();
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      total++;
      assert (expq.size() != 0) else begin
        bad++;
        $error("FAIL rsp_unexpected observed id=%0d result=%0h expected=none", rsp_id, rsp_result);
      end
      if (expq.size() != 0) chk("rsp", 32'({rsp_id, rsp_result}), 32'(expq.pop_front()));
    end
  endtask

  task automatic issue_one(input int i, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] e, input bit track);
    cyc();
    req_valid = NREQ'(1) << i;
    set_req(i, op, a, b);
    #1;
    chk("issue_rdy", 32'(req_ready), 32'(NREQ'(1) << i));
    if (track && req_ready[i]) expq.push_back({IDW'(i), e});
    watch_rsp();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      req_valid = '0;
      #1;
      watch_rsp();
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    cyc();
  endtask

  logic [NREQ-1:0] pv;
  logic [1:0]      rop [NREQ];
  logic [15:0]     ra  [NREQ];
  logic [15:0]     rb  [NREQ];
  int              acc;

  initial begin
    req_valid  = 4'hF;
    req_opcode = '0;
    req_dataa  = '0;
    req_datab  = '0;
    rsp_ready  = 1'b0;

    // Reset values, with all requesters asserting valid
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'h0);
    chk("rst_alu_dataa", 32'(alu_dataa), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    req_valid = '0;
    cyc();
    cyc();

    // 1: single ADD on requester 0
    cyc();
    req_valid = 4'b0001;
    set_req(0, OP_ADD, 16'd5, 16'd7);
    rsp_ready = 1'b1;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    chk("t1_alu_opcode", 32'(alu_opcode), 32'(OP_ADD));
    chk("t1_alu_dataa", 32'(alu_dataa), 32'd5);
    chk("t1_alu_datab", 32'(alu_datab), 32'd7);
    cyc(); req_valid = '0; #1;
    chk("t1_rsp_valid_t1", 32'(rsp_valid), 32'h0);
    chk("t1_busy_t1", 32'(busy), 32'h1);
    cyc(); #1;
    chk("t1_rsp_valid_t2", 32'(rsp_valid), 32'h0);
    cyc(); #1;
    chk("t1_rsp_valid_t3", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_id", 32'(rsp_id), 32'h0);
    chk("t1_rsp_result", 32'(rsp_result), 32'd12);
    cyc(); #1;
    chk("t1_rsp_valid_t4", 32'(rsp_valid), 32'h0);
    chk("t1_busy_t4", 32'(busy), 32'h0);

    // 2: round-robin with all requesters valid
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) expq.push_back({IDW'(k % 4), 16'd7});
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (k < 8) begin
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) set_req(i, OP_SUB_AB, 16'd10, 16'd3);
      end else begin
        req_valid = '0;
      end
      #1;
      if (k < 8) chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      watch_rsp();
    end
    chk("rr_drained", 32'(expq.size()), 32'd0);

    // 3: backpressure, requester 1 always valid
    rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      req_valid = 4'b0010;
      set_req(1, OP_ADD, 16'(100 + acc), 16'd0);
      #1;
      if (req_ready[1]) begin
        expq.push_back({IDW'(1), 16'(100 + acc)});
        acc++;
      end
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_stalled", 32'(req_ready), 32'h0);
    chk("bp_rsp_held", 32'(rsp_valid), 32'h1);
    cyc();
    rsp_ready = 1'b1;
    #1;
    chk("bp_pop_same_cycle_no_credit", 32'(req_ready), 32'h0);
    watch_rsp();
    cyc(); #1;
    chk("bp_resume", 32'(req_ready), 32'h2);
    if (req_ready[1]) expq.push_back({IDW'(1), 16'd104});
    watch_rsp();
    idle(10);
    chk("bp_drained", 32'(expq.size()), 32'd0);

    // 4: wrap / sign cases
    issue_one(0, OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1);
    issue_one(1, OP_SUB_BA, 16'h0001, 16'h0000, 16'hFFFF, 1'b1);
    issue_one(2, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
    idle(6);
    chk("wrap_drained", 32'(expq.size()), 32'd0);

    // 5: asynchronous reset with ops in flight
    rsp_ready = 1'b0;
    issue_one(0, OP_ADD, 16'd1, 16'd2, 16'd3, 1'b0);
    issue_one(1, OP_ADD, 16'd1, 16'd2, 16'd3, 1'b0);
    issue_one(2, OP_ADD, 16'd1, 16'd2, 16'd3, 1'b0);
    req_valid = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_alu_dataa", 32'(alu_dataa), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    chk("post_rst_busy", 32'(busy), 32'h0);
    cyc();
    req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 16'd1, 16'd1);
    #1;
    chk("post_rst_ptr0", 32'(req_ready), 32'h1);
    if (req_ready[0]) expq.push_back({IDW'(0), 16'd2});
    idle(6);
    chk("post_rst_drained", 32'(expq.size()), 32'd0);

    // 6: FIFO pre-filled with 3, then random traffic against the scoreboard
    rsp_ready = 1'b0;
    issue_one(0, OP_SUB_AB, 16'd50, 16'd8, 16'd42, 1'b1);
    issue_one(1, OP_MUL, 16'd300, 16'd3, 16'd900, 1'b1);
    issue_one(2, OP_SUB_BA, 16'd9, 16'd4, 16'hFFFB, 1'b1);
    idle(3);
    chk("fill_busy", 32'(busy), 32'h1);
    pv = '0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
          pv[i]  = 1'b1;
          rop[i] = 2'($urandom_range(0, 3));
          ra[i]  = 16'($urandom);
          rb[i]  = 16'($urandom);
        end
        set_req(i, rop[i], ra[i], rb[i]);
      end
      req_valid = pv;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rand_onehot", 32'($onehot0(req_ready)), 32'h1);
      chk("rand_subset", 32'(req_ready & ~pv), 32'h0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && pv[i]) begin
          expq.push_back({IDW'(i), alu_ref(rop[i], ra[i], rb[i])});
          pv[i] = 1'b0;
        end
      end
      watch_rsp();
    end
    rsp_ready = 1'b1;
    idle(12);
    chk("rand_drained", 32'(expq.size()), 32'd0);
    chk("rand_idle_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
